ddr_wr_burst_arbiter: RTL and testbench

Round-robin scheduler that shares one DDR write port among N_CH prefetch-FIFO read sides (valid/enable handshake: `rd_vld` out of the FIFO, `rd_en` into it). For each granted channel it issues one fixed-length write command with an address from that channel's pointer, then streams exactly BURST_LEN beats from that channel's FIFO to the DDR data port. It also maintains each channel's wrapping frame-buffer address pointer. It sits between the per-channel frame FIFOs and the DDR controller's write command and data interface.

---
 rtl/ddr_wr_burst_arbiter.sv | 171 +++++++++++++++++
 tb/tb_ddr_wr_burst_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_wr_burst_arbiter.sv
// ddr_wr_burst_arbiter
//   Round-robin scheduler sharing one DDR write port among N_CH prefetch
//   FIFOs. A grant issues one fixed-length write command at the channel's
//   current frame-buffer pointer, then streams BURST_LEN beats from that
//   channel's FIFO. Each channel keeps a pointer that wraps inside its
//   [base, base+size) region.
// Ports:
//   clk, rst                  clock, async active-high reset
//   ch_req/ch_rd_vld/ch_rd_data/ch_rd_en   per-channel FIFO read side
//   ch_base/ch_size/ch_frame_start         per-channel region + rewind pulse
//   cmd_valid/cmd_ready/cmd_addr/cmd_len   DDR write command
//   wdata_valid/wdata_ready/wdata/wdata_last  DDR write data
//   grant, busy               current owner (one-hot) and non-idle flag

// Per-channel wrapping address pointer.
module ddr_wr_ptr_lane #(
  parameter int unsigned ADDR_W = 28,
  parameter logic [ADDR_W:0] INC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] size,
  input  logic              frame_start,
  input  logic              owned,        // channel holds the current burst
  input  logic              done,         // last beat of this channel's burst
  output logic [ADDR_W-1:0] ptr
);
  logic              pend;
  logic [ADDR_W:0]   sum_w, end_w;

  // One extra bit so a region ending exactly at 2**ADDR_W still wraps.
  assign sum_w = {1'b0, ptr} + INC;
  assign end_w = {1'b0, base} + {1'b0, size};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr  <= '0;
      pend <= 1'b0;
    end else if (done) begin
      // A rewind requested during the burst (or on its last beat) wins.
      if (pend || frame_start || (sum_w >= end_w)) ptr <= base;
      else                                         ptr <= sum_w[ADDR_W-1:0];
      pend <= 1'b0;
    end else if (frame_start) begin
      if (owned) pend <= 1'b1;
      else       ptr  <= base;
    end
  end
endmodule

module ddr_wr_burst_arbiter #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned ADDR_W     = 28,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned BEAT_BYTES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_req,
  input  logic [N_CH-1:0]          ch_rd_vld,
  input  logic [N_CH*DATA_W-1:0]   ch_rd_data,
  output logic [N_CH-1:0]          ch_rd_en,
  input  logic [N_CH*ADDR_W-1:0]   ch_base,
  input  logic [N_CH*ADDR_W-1:0]   ch_size,
  input  logic [N_CH-1:0]          ch_frame_start,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [ADDR_W-1:0]        cmd_addr,
  output logic [7:0]               cmd_len,
  output logic                     wdata_valid,
  input  logic                     wdata_ready,
  output logic [DATA_W-1:0]        wdata,
  output logic                     wdata_last,
  output logic [N_CH-1:0]          grant,
  output logic                     busy
);
  localparam int unsigned CW = $clog2(N_CH);
  localparam int unsigned BW = $clog2(BURST_LEN);
  localparam logic [ADDR_W:0] INC = (ADDR_W+1)'(BURST_LEN * BEAT_BYTES);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                        state;
  logic [CW-1:0]                 rr_ptr, g_idx, sel_idx, g_nxt;
  logic                          sel_vld;
  logic [BW-1:0]                 beat_cnt;
  logic                          in_data, hs, last_beat, burst_done;
  logic [N_CH-1:0][ADDR_W-1:0]   ptr;

  assign cmd_len = 8'(BURST_LEN - 1);

  // First requester at or after rr_ptr, circularly.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!sel_vld && ch_req[idx]) begin
        sel_vld = 1'b1;
        sel_idx = CW'(idx);
      end
    end
  end

  // Data path is purely combinational from the owner's FIFO: no added latency.
  assign in_data     = (state == DATA);
  assign wdata_valid = in_data & ch_rd_vld[g_idx];
  assign wdata       = in_data ? ch_rd_data[int'(g_idx)*DATA_W +: DATA_W] : '0;
  assign ch_rd_en    = (in_data && wdata_ready) ? grant : '0;
  assign hs          = wdata_valid & wdata_ready;
  assign last_beat   = (beat_cnt == BW'(BURST_LEN - 1));
  assign wdata_last  = in_data & last_beat;
  assign burst_done  = hs & last_beat;
  assign g_nxt       = (g_idx == CW'(N_CH - 1)) ? '0 : g_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      g_idx     <= '0;
      rr_ptr    <= '0;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      busy      <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (sel_vld) begin
          state     <= CMD;
          grant     <= N_CH'(1) << sel_idx;
          g_idx     <= sel_idx;
          cmd_addr  <= ptr[sel_idx];
          cmd_valid <= 1'b1;
          busy      <= 1'b1;
        end
        CMD: if (cmd_ready) begin
          state     <= DATA;
          cmd_valid <= 1'b0;
          beat_cnt  <= '0;
        end
        DATA: if (hs) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (last_beat) begin
            state  <= IDLE;
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= g_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    ddr_wr_ptr_lane #(.ADDR_W(ADDR_W), .INC(INC)) u_lane (
      .clk         (clk),
      .rst         (rst),
      .base        (ch_base[i*ADDR_W +: ADDR_W]),
      .size        (ch_size[i*ADDR_W +: ADDR_W]),
      .frame_start (ch_frame_start[i]),
      .owned       (busy & grant[i]),
      .done        (burst_done & grant[i]),
      .ptr         (ptr[i])
    );
  end
endmodule

// File: tb/tb_ddr_wr_burst_arbiter.sv
// Bench for ddr_wr_burst_arbiter: table of directed bursts, hand-written
// frame_start / reset sequences, and a randomized backpressure run checked
// cycle by cycle against a transaction-level reference model.
module tb_ddr_wr_burst_arbiter;
  localparam int N  = 4;
  localparam int DW = 128;
  localparam int AW = 28;
  localparam int BL = 16;
  localparam int BB = 16;
  localparam longint INC = BL * BB;

  logic              clk = 1'b0, rst = 1'b1;
  logic [N-1:0]      ch_req = '0, ch_rd_vld = '0, ch_rd_en, ch_frame_start = '0;
  logic [N*DW-1:0]   ch_rd_data;
  logic [N*AW-1:0]   ch_base, ch_size;
  logic              cmd_valid, cmd_ready = 1'b0, wdata_valid, wdata_ready = 1'b0;
  logic              wdata_last, busy;
  logic [AW-1:0]     cmd_addr;
  logic [7:0]        cmd_len;
  logic [DW-1:0]     wdata;
  logic [N-1:0]      grant;

  ddr_wr_burst_arbiter #(.N_CH(N), .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL),
                         .BEAT_BYTES(BB)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_rd_vld(ch_rd_vld),
    .ch_rd_data(ch_rd_data), .ch_rd_en(ch_rd_en), .ch_base(ch_base),
    .ch_size(ch_size), .ch_frame_start(ch_frame_start), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .wdata_last(wdata_last), .grant(grant), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Source FIFOs: endless tagged words, popped on rd_en & rd_vld.
  function automatic logic [DW-1:0] mk(input int ch, input int s);
    return {32'(ch), 32'(s), 32'hA5A5_5A5A ^ 32'(s), 32'(s * 3 + 1)};
  endfunction

  int            src_seq[N];
  logic [N-1:0]  pop_mask = '0;
  logic [AW-1:0] base_a[N], size_a[N];

  initial for (int i = 0; i < N; i++) begin
    src_seq[i] = 0; base_a[i] = '0; size_a[i] = AW'(INC);
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ch_rd_data[i*DW +: DW] = mk(i, src_seq[i]);
      ch_base[i*AW +: AW]    = base_a[i];
      ch_size[i*AW +: AW]    = size_a[i];
    end
  end

  always @(posedge clk)
    for (int i = 0; i < N; i++) if (pop_mask[i]) src_seq[i] <= src_seq[i] + 1;

  // Reference model: burst-level phase (0 idle, 1 command, 2 data), owner,
  // pointers, pending rewinds. Advanced once per cycle from the inputs.
  int            m_phase = 0, m_g = 0, m_beats = 0, m_rr = 0, m_bursts = 0;
  int            exp_seq[N];
  logic [AW-1:0] m_ptr[N], m_addr = '0;
  bit            m_pend[N];

  initial for (int i = 0; i < N; i++) begin exp_seq[i] = 0; m_ptr[i] = '0; m_pend[i] = 0; end

  always @(negedge clk) begin : mon
    logic [N-1:0] exp_g, exp_en;
    bit exp_wv, mhs, done;
    int old_phase, idx;
    longint s, e;
    if (rst) begin
      m_phase = 0; m_rr = 0; m_beats = 0; pop_mask <= '0;
      for (int i = 0; i < N; i++) begin m_ptr[i] = '0; m_pend[i] = 0; end
    end else begin
      exp_g  = (m_phase != 0) ? N'(1 << m_g) : '0;
      exp_wv = (m_phase == 2) && ch_rd_vld[m_g];
      exp_en = (m_phase == 2 && wdata_ready) ? exp_g : '0;
      chk("m_busy", DW'(busy), DW'(m_phase != 0));
      chk("m_grant", DW'(grant), DW'(exp_g));
      chk("m_cmd_valid", DW'(cmd_valid), DW'(m_phase == 1));
      if (m_phase == 1) chk("m_cmd_addr", DW'(cmd_addr), DW'(m_addr));
      chk("m_wdata_valid", DW'(wdata_valid), DW'(exp_wv));
      chk("m_rd_en", DW'(ch_rd_en), DW'(exp_en));
      mhs = exp_wv && wdata_ready;
      if (mhs) begin
        chk("m_wdata", wdata, mk(m_g, exp_seq[m_g]));
        chk("m_wdata_last", DW'(wdata_last), DW'(m_beats == BL - 1));
      end
      pop_mask <= ch_rd_en & ch_rd_vld;
      old_phase = m_phase;
      done = 0;
      case (m_phase)
        0: if (ch_req != '0) begin
          for (int k = N - 1; k >= 0; k--) begin
            idx = (m_rr + k) % N;
            if (ch_req[idx]) m_g = idx;
          end
          m_addr = m_ptr[m_g];
          m_phase = 1;
        end
        1: if (cmd_ready) begin m_phase = 2; m_beats = 0; end
        default: if (mhs) begin
          exp_seq[m_g]++; m_beats++;
          if (m_beats == BL) done = 1;
        end
      endcase
      for (int i = 0; i < N; i++)
        if (ch_frame_start[i]) begin
          if (old_phase != 0 && m_g == i) m_pend[i] = 1;
          else m_ptr[i] = base_a[i];
        end
      if (done) begin
        s = longint'(m_ptr[m_g]) + INC;
        e = longint'(base_a[m_g]) + longint'(size_a[m_g]);
        if (m_pend[m_g] || s >= e) m_ptr[m_g] = base_a[m_g];
        else m_ptr[m_g] = AW'(s);
        m_pend[m_g] = 0;
        m_rr = (m_g + 1) % N;
        m_phase = 0;
        m_bursts++;
      end
    end
  end

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  g;
    logic [AW-1:0] addr;
    int            dly;     // cycles cmd_ready is withheld
    int            fs_beat; // beat index during which fs is pulsed (-1 none)
    logic [N-1:0]  fs;
  } vec_t;

  // Starts with the state idle at posedge+1; returns at posedge+1 after the last beat.
  task automatic run_burst(input vec_t v, input int n);
    int nb, cyc;
    bit done;
    string t;
    t = $sformatf("v%0d", n);
    ch_req = v.req;
    @(negedge clk); chk({t, "_idle_gap"}, DW'(cmd_valid), DW'(0));
    @(negedge clk);
    chk({t, "_cmd_valid"}, DW'(cmd_valid), DW'(1));
    chk({t, "_grant"}, DW'(grant), DW'(v.g));
    chk({t, "_cmd_addr"}, DW'(cmd_addr), DW'(v.addr));
    for (int k = 0; k < v.dly; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk({t, "_cmd_hold_valid"}, DW'(cmd_valid), DW'(1));
      chk({t, "_cmd_hold_addr"}, DW'(cmd_addr), DW'(v.addr));
    end
    @(posedge clk); #1 cmd_ready = 1'b1;
    @(posedge clk); #1 cmd_ready = 1'b0;
    nb = 0; done = 0;
    for (cyc = 0; cyc < 4 * BL && !done; cyc++) begin
      @(negedge clk);
      if (wdata_valid && wdata_ready) begin
        nb++;
        if (wdata_last) done = 1;
      end
      @(posedge clk); #1 ch_frame_start = (!done && nb == v.fs_beat) ? v.fs : '0;
    end
    chk({t, "_beats"}, DW'(nb), DW'(BL));
    chk({t, "_cycles"}, DW'(cyc), DW'(BL));
  endtask

  vec_t tbl[14];
  int   nb, cyc;

  initial begin
    // Row: req, grant, addr, cmd delay, frame_start beat, frame_start mask.
    tbl[0]  = '{4'b0001, 4'b0001, 28'h1000, 0, -1, 4'b0000};
    tbl[1]  = '{4'b0001, 4'b0001, 28'h1100, 2, -1, 4'b0000};
    tbl[2]  = '{4'b1111, 4'b0010, 28'h2000, 1, -1, 4'b0000};
    tbl[3]  = '{4'b1111, 4'b0100, 28'h3000, 0, -1, 4'b0000};
    tbl[4]  = '{4'b1111, 4'b1000, 28'h4000, 3, -1, 4'b0000};
    tbl[5]  = '{4'b1111, 4'b0001, 28'h1200, 0, -1, 4'b0000};
    tbl[6]  = '{4'b1111, 4'b0010, 28'h2100, 1, -1, 4'b0000};
    tbl[7]  = '{4'b1111, 4'b0100, 28'h3100, 0, -1, 4'b0000};
    tbl[8]  = '{4'b1011, 4'b1000, 28'h4100, 0, -1, 4'b0000};
    tbl[9]  = '{4'b0001, 4'b0001, 28'h1300, 0, -1, 4'b0000};
    tbl[10] = '{4'b0001, 4'b0001, 28'h1000, 1, -1, 4'b0000}; // wrapped
    tbl[11] = '{4'b0001, 4'b0001, 28'h1100, 0,  5, 4'b0011}; // rewind mid-burst
    tbl[12] = '{4'b0001, 4'b0001, 28'h1000, 0, -1, 4'b0000};
    tbl[13] = '{4'b0010, 4'b0010, 28'h2000, 0, -1, 4'b0000}; // idle rewind took

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_valid", DW'(cmd_valid), DW'(0));
    chk("rst_wdata_valid", DW'(wdata_valid), DW'(0));
    chk("rst_wdata_last", DW'(wdata_last), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_grant", DW'(grant), DW'(0));
    chk("rst_rd_en", DW'(ch_rd_en), DW'(0));
    chk("rst_cmd_addr", DW'(cmd_addr), DW'(0));
    chk("rst_wdata", wdata, DW'(0));
    chk("rst_cmd_len", DW'(cmd_len), DW'(BL - 1));
    @(posedge clk); #1 rst = 1'b0;

    // Configure regions and rewind every channel.
    for (int i = 0; i < N; i++) begin
      base_a[i] = AW'(32'h1000 * (i + 1)); size_a[i] = AW'(32'h400);
    end
    ch_rd_vld = '1; wdata_ready = 1'b1;
    ch_frame_start = '1;
    @(posedge clk); #1 ch_frame_start = '0;

    foreach (tbl[r]) run_burst(tbl[r], r);

    // Reset during beat 7 of a ch0 burst.
    ch_req = 4'b0001;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!cmd_valid && cyc < 10);
    chk("rb_cmd_seen", DW'(cmd_valid), DW'(1));
    @(posedge clk); #1 cmd_ready = 1'b1;
    @(posedge clk); #1 cmd_ready = 1'b0;
    nb = 0; cyc = 0;
    while (nb < 7 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (wdata_valid && wdata_ready) nb++;
    end
    chk("rb_beats_before_rst", DW'(nb), DW'(7));
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("rb_cmd_valid", DW'(cmd_valid), DW'(0));
    chk("rb_wdata_valid", DW'(wdata_valid), DW'(0));
    chk("rb_wdata_last", DW'(wdata_last), DW'(0));
    chk("rb_busy", DW'(busy), DW'(0));
    chk("rb_grant", DW'(grant), DW'(0));
    chk("rb_rd_en", DW'(ch_rd_en), DW'(0));
    chk("rb_wdata", wdata, DW'(0));
    chk("rb_cmd_addr", DW'(cmd_addr), DW'(0));
    ch_req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // rr_ptr back to 0 and pointers back to 0.
    run_burst('{4'b1111, 4'b0001, 28'h0, 0, -1, 4'b0000}, 99);
    ch_req = '0;

    // Randomized backpressure over mixed regions; ch3 ends at 2**AW.
    base_a[0] = 28'h0;        size_a[0] = 28'h100;
    base_a[1] = 28'h0080000;  size_a[1] = 28'h300;
    base_a[2] = 28'h0123400;  size_a[2] = 28'h400;
    base_a[3] = 28'hFFFFE00;  size_a[3] = 28'h200;
    @(posedge clk); #1 ch_frame_start = '1;
    @(posedge clk); #1 ch_frame_start = '0;
    for (int c = 0; c < 4000; c++) begin
      ch_req      = N'($urandom_range(0, 15));
      ch_rd_vld   = N'($urandom);
      wdata_ready = ($urandom_range(0, 3) != 0);
      cmd_ready   = ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
    end
    ch_req = '0; ch_rd_vld = '1; wdata_ready = 1'b1; cmd_ready = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (busy && cyc < 100);
    chk("drain_idle", DW'(busy), DW'(0));
    chk("random_progress", DW'(m_bursts > 40), DW'(1));
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
